// File: rtl/free_play_pkg.sv
// Shared definitions for the free-play engine.
//   - FSM state encodings as seen on the engine's state output
//   - indices of the three raw buttons
//   - hp_of(): clock cycles per half period of a tone
//   - base_freq(): note frequencies of the stored base octave, up to 16 keys
package free_play_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_PLAY    = 2'b01,
      ST_SUSTAIN = 2'b10
   } state_e;

   localparam int BTN_DOWN    = 0;
   localparam int BTN_UP      = 1;
   localparam int BTN_SUSTAIN = 2;

   // Half period in clock cycles, rounded down.
   function automatic int unsigned hp_of(input int unsigned freq_hz, input int unsigned clk_hz);
      return clk_hz / (2 * freq_hz);
   endfunction

   // C D E F G A B C' D' E' F' G' A' B' C'' D'' of the base octave.
   function automatic int unsigned base_freq(input int idx);
      case (idx)
         0:       return 262;
         1:       return 294;
         2:       return 330;
         3:       return 349;
         4:       return 392;
         5:       return 440;
         6:       return 494;
         7:       return 523;
         8:       return 587;
         9:       return 659;
         10:      return 698;
         11:      return 784;
         12:      return 880;
         13:      return 988;
         14:      return 1047;
         15:      return 1175;
         default: return 262;
      endcase
   endfunction

endpackage

// File: rtl/free_play_engine_btn_debounce.sv
// Button conditioner: two-flop synchroniser, stability counter and a one-shot
// event pulse.
//   clk_i    system clock
//   reset_i  synchronous active-high reset
//   btn_i    raw asynchronous button level
//   pulse_o  one-cycle registered pulse, issued once per press after the
//            synchronised level has been high for DEBOUNCE_CYCLES cycles
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic btn_i,
   output logic pulse_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fired_q, fired_d;
   logic             pulse_q, pulse_d;

   // Count stable-high cycles; any low sample restarts the count and re-arms
   // the pulse. fired_q blocks a second pulse while the button stays down.
   always_comb begin
      cnt_d   = cnt_q;
      fired_d = fired_q;
      pulse_d = 1'b0;
      if (!sync2_q) begin
         cnt_d   = '0;
         fired_d = 1'b0;
      end else if (!fired_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            pulse_d = 1'b1;
            fired_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchroniser and counter registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         fired_q <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         fired_q <= fired_d;
         pulse_q <= pulse_d;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/free_play_engine.sv
// Free-play piano engine: key selection, octave control, timed sustain and
// square-wave tone generation driving the buzzer directly.
//   clk_i        system clock
//   reset_i      synchronous active-high reset
//   en_i         mode enable; low acts as reset for everything but the debouncers
//   button_i     raw buttons: [0] octave down, [1] octave up, [2] sustain toggle
//   sw_i         key switches, 1 = pressed; highest set index wins
//   melody_o     buzzer square wave
//   ledsw_o      sw_i mirrored, gated by en_i
//   ledrange_o   one-hot current octave
//   note_idx_o   index of the sounding (or last) key
//   octave_o     current octave index
//   state_o      00 idle, 01 play, 10 sustain
//   sustain_on_o sustain mode flag
module free_play_engine
   import free_play_pkg::*;
#(
   parameter int unsigned NUM_KEYS        = 8,
   parameter int unsigned NUM_OCTAVES     = 3,
   parameter int unsigned BASE_OCT        = 1,
   parameter int unsigned CLK_HZ          = 100_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned SUSTAIN_CYCLES  = 25_000_000,
   parameter int unsigned HP_W            = 24,
   localparam int KEY_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1,
   localparam int OCT_W = (NUM_OCTAVES > 1) ? $clog2(NUM_OCTAVES) : 1
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   en_i,
   input  logic [2:0]             button_i,
   input  logic [NUM_KEYS-1:0]    sw_i,
   output logic                   melody_o,
   output logic [NUM_KEYS-1:0]    ledsw_o,
   output logic [NUM_OCTAVES-1:0] ledrange_o,
   output logic [KEY_W-1:0]       note_idx_o,
   output logic [OCT_W-1:0]       octave_o,
   output logic [1:0]             state_o,
   output logic                   sustain_on_o
);

   localparam int HOLD_W = $clog2(SUSTAIN_CYCLES + 1);
   localparam logic [NUM_OCTAVES-1:0] RANGE_RST = NUM_OCTAVES'(1) << BASE_OCT;

   logic [2:0]             btnEvent;
   logic [HP_W-1:0]        hpTable [NUM_KEYS];
   logic [HP_W-1:0]        hpBase, hpCur;
   logic [KEY_W-1:0]       keyIdx;
   logic                   keyPressed;
   logic                   restart;

   state_e                 state_q, state_d;
   logic [OCT_W-1:0]       octave_q, octave_d;
   logic                   sustain_q, sustain_d;
   logic [KEY_W-1:0]       note_q, note_d;
   logic [NUM_KEYS-1:0]    ledsw_q, ledsw_d;
   logic [NUM_OCTAVES-1:0] ledrange_q, ledrange_d;
   logic                   melody_q, melody_d;
   logic [HP_W-1:0]        toneCnt_q, toneCnt_d;
   logic [HOLD_W-1:0]      holdCnt_q, holdCnt_d;

   for (genvar b = 0; b < 3; b++) begin : g_btn
      btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
         .clk_i   (clk_i),
         .reset_i (reset_i),
         .btn_i   (button_i[b]),
         .pulse_o (btnEvent[b])
      );
   end

   // Half-period table of the base octave, folded to constants at elaboration.
   for (genvar g = 0; g < NUM_KEYS; g++) begin : g_hp
      assign hpTable[g] = HP_W'(hp_of(base_freq(g), CLK_HZ));
   end

   // Highest pressed key wins, so the loop lets later indices overwrite.
   always_comb begin
      keyIdx = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (sw_i[i]) keyIdx = KEY_W'(i);
      end
   end
   assign keyPressed = |sw_i;

   // Octaves above the base halve the period per step, octaves below double it.
   always_comb begin
      hpBase = hpTable[note_q];
      if (octave_q >= OCT_W'(BASE_OCT)) hpCur = hpBase >> (octave_q - OCT_W'(BASE_OCT));
      else                              hpCur = hpBase << (OCT_W'(BASE_OCT) - octave_q);
   end

   // Next-state logic for the FSM, octave/sustain controls and tone counter.
   // restart clears the tone counter without touching the melody level, so a
   // new note or octave produces its first edge a full half period later.
   always_comb begin
      state_d    = state_q;
      octave_d   = octave_q;
      sustain_d  = sustain_q;
      note_d     = note_q;
      ledsw_d    = ledsw_q;
      ledrange_d = ledrange_q;
      melody_d   = melody_q;
      toneCnt_d  = toneCnt_q;
      holdCnt_d  = holdCnt_q;
      restart    = 1'b0;
      if (!en_i) begin
         state_d    = ST_IDLE;
         octave_d   = OCT_W'(BASE_OCT);
         sustain_d  = 1'b0;
         note_d     = '0;
         ledsw_d    = '0;
         ledrange_d = RANGE_RST;
         melody_d   = 1'b0;
         toneCnt_d  = '0;
         holdCnt_d  = '0;
      end else begin
         ledsw_d = sw_i;
         if (btnEvent[BTN_UP] && !btnEvent[BTN_DOWN] &&
             octave_q != OCT_W'(NUM_OCTAVES - 1)) begin
            octave_d = octave_q + 1'b1;
         end else if (btnEvent[BTN_DOWN] && !btnEvent[BTN_UP] && octave_q != '0) begin
            octave_d = octave_q - 1'b1;
         end
         ledrange_d = NUM_OCTAVES'(1) << octave_d;
         if (btnEvent[BTN_SUSTAIN]) sustain_d = !sustain_q;
         restart = (octave_d != octave_q);

         case (state_q)
            ST_IDLE: begin
               if (keyPressed) begin
                  state_d = ST_PLAY;
                  note_d  = keyIdx;
                  restart = 1'b1;
               end
            end
            ST_PLAY: begin
               if (keyPressed) begin
                  if (keyIdx != note_q) begin
                     note_d  = keyIdx;
                     restart = 1'b1;
                  end
               end else if (sustain_q) begin
                  state_d   = ST_SUSTAIN;
                  holdCnt_d = '0;
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_SUSTAIN: begin
               if (keyPressed) begin
                  state_d = ST_PLAY;
                  note_d  = keyIdx;
                  restart = 1'b1;
               end else if (btnEvent[BTN_SUSTAIN] && sustain_q) begin
                  state_d = ST_IDLE;
               end else if (holdCnt_q == HOLD_W'(SUSTAIN_CYCLES - 1)) begin
                  state_d = ST_IDLE;
               end else begin
                  holdCnt_d = holdCnt_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase

         if (state_d == ST_IDLE) begin
            melody_d  = 1'b0;
            toneCnt_d = '0;
         end else if (restart) begin
            toneCnt_d = '0;
         end else if (toneCnt_q == hpCur - 1'b1) begin
            melody_d  = !melody_q;
            toneCnt_d = '0;
         end else begin
            toneCnt_d = toneCnt_q + 1'b1;
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= ST_IDLE;
         octave_q   <= OCT_W'(BASE_OCT);
         sustain_q  <= 1'b0;
         note_q     <= '0;
         ledsw_q    <= '0;
         ledrange_q <= RANGE_RST;
         melody_q   <= 1'b0;
         toneCnt_q  <= '0;
         holdCnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         octave_q   <= octave_d;
         sustain_q  <= sustain_d;
         note_q     <= note_d;
         ledsw_q    <= ledsw_d;
         ledrange_q <= ledrange_d;
         melody_q   <= melody_d;
         toneCnt_q  <= toneCnt_d;
         holdCnt_q  <= holdCnt_d;
      end
   end

   assign melody_o     = melody_q;
   assign ledsw_o      = ledsw_q;
   assign ledrange_o   = ledrange_q;
   assign note_idx_o   = note_q;
   assign octave_o     = octave_q;
   assign state_o      = state_q;
   assign sustain_on_o = sustain_q;

endmodule

// File: tb/tb_free_play_engine.sv
// Self-checking bench for free_play_engine with a 1 MHz clock, 4-cycle
// debounce and 100-cycle sustain. Expected values are queued as each scenario
// drives stimulus and are popped against the observed DUT outputs.
module tb_free_play_engine;

   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic [2:0] button;
   logic [7:0] sw;
   logic       melody;
   logic [7:0] ledsw;
   logic [2:0] ledrange;
   logic [2:0] noteIdx;
   logic [1:0] octave;
   logic [1:0] state;
   logic       sustainOn;

   typedef struct {
      string name;
      int    value;
   } exp_t;

   exp_t expQ[$];
   int   obsQ[$];
   int   checks = 0;
   int   errors = 0;

   free_play_engine #(
      .CLK_HZ          (1_000_000),
      .DEBOUNCE_CYCLES (4),
      .SUSTAIN_CYCLES  (100)
   ) dut (
      .clk_i        (clk),
      .reset_i      (reset),
      .en_i         (en),
      .button_i     (button),
      .sw_i         (sw),
      .melody_o     (melody),
      .ledsw_o      (ledsw),
      .ledrange_o   (ledrange),
      .note_idx_o   (noteIdx),
      .octave_o     (octave),
      .state_o      (state),
      .sustain_on_o (sustainOn)
   );

   // 100 MHz simulation clock; only cycle counts matter.
   always #5 clk = ~clk;

   task automatic pushExp(input string name, input int value);
      expQ.push_back('{name, value});
   endtask

   task automatic observe(input int value);
      obsQ.push_back(value);
   endtask

   // Counts falling edges until melody changes level; -1 on timeout.
   task automatic waitChange(output int n);
      logic startLvl;
      startLvl = melody;
      n = 0;
      while (melody == startLvl && n < 20000) begin
         @(negedge clk);
         n++;
      end
      if (melody == startLvl) n = -1;
   endtask

   // Skips to the next toggle, then measures one full half period.
   task automatic measureHp(output int hp);
      int a;
      waitChange(a);
      waitChange(hp);
      if (a < 0) hp = -1;
   endtask

   task automatic pressButton(input int b, input int cycles);
      button[b] = 1'b1;
      repeat (cycles) @(negedge clk);
      button[b] = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic observeResetValues();
      observe(state);    pushExp("rst state", 0);
      observe(melody);   pushExp("rst melody", 0);
      observe(noteIdx);  pushExp("rst note_idx", 0);
      observe(octave);   pushExp("rst octave", 1);
      observe(ledrange); pushExp("rst ledrange", 3'b010);
      observe(ledsw);    pushExp("rst ledsw", 0);
      observe(sustainOn); pushExp("rst sustain_on", 0);
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 1'b1; button = '0; sw = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      observeResetValues();
      while (expQ.size() != 0) begin
         exp_t e; int o;
         e = expQ.pop_front();
         o = (obsQ.size() != 0) ? obsQ.pop_front() : -999;
         checks++;
         if (o !== e.value) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", e.name, o, e.value);
         end
      end
   endtask

   task automatic test_play();
      int lat, hp;
      sw = 8'b0000_0001;
      pushExp("play state", 1);
      pushExp("play note_idx", 0);
      pushExp("play octave", 1);
      pushExp("play ledsw", 1);
      pushExp("play first toggle", 1909);
      pushExp("play hp", 1908);
      @(negedge clk);
      observe(state); observe(noteIdx); observe(octave); observe(ledsw);
      waitChange(lat);
      observe(lat < 0 ? -1 : lat + 1);
      waitChange(hp);
      observe(hp);
      while (expQ.size() != 0) begin
         exp_t e; int o;
         e = expQ.pop_front();
         o = (obsQ.size() != 0) ? obsQ.pop_front() : -999;
         checks++;
         if (o !== e.value) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", e.name, o, e.value);
         end
      end
   endtask

   task automatic test_octave();
      int hp;
      pushExp("up octave", 2); pushExp("up ledrange", 3'b100); pushExp("up hp", 954);
      pressButton(1, 6);
      observe(octave); observe(ledrange);
      measureHp(hp); observe(hp);
      pushExp("sat octave", 2); pushExp("sat ledrange", 3'b100);
      pressButton(1, 6);
      observe(octave); observe(ledrange);
      pushExp("down octave", 0); pushExp("down ledrange", 3'b001); pushExp("down hp", 3816);
      pressButton(0, 6);
      pressButton(0, 6);
      observe(octave); observe(ledrange);
      measureHp(hp); observe(hp);
      pushExp("floor octave", 0);
      pressButton(0, 6);
      observe(octave);
      while (expQ.size() != 0) begin
         exp_t e; int o;
         e = expQ.pop_front();
         o = (obsQ.size() != 0) ? obsQ.pop_front() : -999;
         checks++;
         if (o !== e.value) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", e.name, o, e.value);
         end
      end
   endtask

   task automatic test_key_priority();
      int hp;
      pressButton(1, 6);
      sw = 8'b1000_0001;
      pushExp("prio note_idx", 7); pushExp("prio hp", 956);
      @(negedge clk);
      observe(noteIdx);
      measureHp(hp); observe(hp);
      sw = 8'b0;
      pushExp("release state", 0); pushExp("release melody", 0);
      @(negedge clk);
      observe(state); observe(melody);
      while (expQ.size() != 0) begin
         exp_t e; int o;
         e = expQ.pop_front();
         o = (obsQ.size() != 0) ? obsQ.pop_front() : -999;
         checks++;
         if (o !== e.value) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", e.name, o, e.value);
         end
      end
   endtask

   task automatic test_sustain();
      int hp, cnt;
      pushExp("sustain flag on", 1);
      pressButton(2, 6);
      observe(sustainOn);
      sw = 8'b0010_0000;
      pushExp("sus play state", 1); pushExp("sus note_idx", 5); pushExp("sus hp", 1136);
      @(negedge clk);
      observe(state); observe(noteIdx);
      measureHp(hp); observe(hp);
      // Release and count the cycles spent in sustain.
      sw = 8'b0;
      pushExp("sustain length", 100);
      pushExp("after sus state", 0); pushExp("after sus melody", 0);
      pushExp("idle keeps note", 5);
      cnt = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (state == 2'b10) cnt++;
         else break;
      end
      observe(cnt); observe(state); observe(melody); observe(noteIdx);
      // Re-press a key halfway through sustain.
      sw = 8'b0010_0000;
      repeat (20) @(negedge clk);
      sw = 8'b0;
      pushExp("mid sus state", 2);
      repeat (50) @(negedge clk);
      observe(state);
      sw = 8'b0000_0100;
      pushExp("repress state", 1); pushExp("repress note_idx", 2); pushExp("repress hp", 1515);
      @(negedge clk);
      observe(state); observe(noteIdx);
      measureHp(hp); observe(hp);
      // Clearing sustain while holding ends the note early.
      sw = 8'b0;
      pushExp("clear sus state", 0); pushExp("clear sus flag", 0);
      pressButton(2, 6);
      observe(state); observe(sustainOn);
      while (expQ.size() != 0) begin
         exp_t e; int o;
         e = expQ.pop_front();
         o = (obsQ.size() != 0) ? obsQ.pop_front() : -999;
         checks++;
         if (o !== e.value) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", e.name, o, e.value);
         end
      end
   endtask

   task automatic test_conflict_glitch();
      pushExp("both btn octave", 1); pushExp("both btn ledrange", 3'b010);
      button = 3'b011;
      repeat (6) @(negedge clk);
      button = 3'b000;
      repeat (10) @(negedge clk);
      observe(octave); observe(ledrange);
      pushExp("glitch octave", 1);
      pressButton(1, 2);
      observe(octave);
      while (expQ.size() != 0) begin
         exp_t e; int o;
         e = expQ.pop_front();
         o = (obsQ.size() != 0) ? obsQ.pop_front() : -999;
         checks++;
         if (o !== e.value) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", e.name, o, e.value);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      // Mid-play reset with the melody high and octave moved off base.
      pressButton(1, 6);
      sw = 8'b0000_1000;
      waitChange(lat);
      reset = 1'b1;
      @(negedge clk);
      observeResetValues();
      reset = 1'b0;
      pushExp("post reset toggle", 1433);
      waitChange(lat);
      observe(lat);
      // Same again with en low instead of reset.
      pressButton(1, 6);
      pushExp("pre en octave", 2);
      observe(octave);
      en = 1'b0;
      @(negedge clk);
      observeResetValues();
      en = 1'b1;
      pushExp("post en toggle", 1433);
      waitChange(lat);
      observe(lat);
      while (expQ.size() != 0) begin
         exp_t e; int o;
         e = expQ.pop_front();
         o = (obsQ.size() != 0) ? obsQ.pop_front() : -999;
         checks++;
         if (o !== e.value) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", e.name, o, e.value);
         end
      end
   endtask

   initial begin
      test_reset();
      test_play();
      test_octave();
      test_key_priority();
      test_sustain();
      test_conflict_glitch();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
